tick_sched: RTL and testbench

Runtime-programmable clock-enable scheduler for the VGA/game design. It replaces fixed, parameter-set clock division with NCH independent single-cycle tick channels, each with a square-wave phase output, all in the main `clk` domain. Divisors are loaded through a valid/ready configuration port. A reconfiguration of a running channel takes effect only on that channel's tick boundary, so no consumer sees a truncated period.

---
 rtl/tick_sched.sv | 153 +++++++++++++++
 tb/tb_tick_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_sched.sv
// tick_sched: NCH runtime-programmable clock-enable channels with square-wave phase
// outputs. Divisors arrive over a valid/ready port and land on the channel's tick edge.
module tick_sched #(
   parameter int unsigned NCH   = 2,
   parameter int unsigned CHW   = 1,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CHW-1:0]   cfg_ch,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_err,
   output logic [NCH-1:0]   tick,
   output logic [NCH-1:0]   phase,
   output logic [NCH-1:0]   running
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic {IDLE, PEND} state_t;

   typedef struct packed {
      logic [CHW-1:0]   ch;
      logic [WIDTH-1:0] div;
   } req_t;

   state_t           state;
   state_t           state_next;
   req_t             hold;
   logic [WIDTH-1:0] div_a [NCH];
   logic [WIDTH-1:0] cnt_a [NCH];
   logic [NCH-1:0]   sel_c;
   logic             ch_valid_c;
   logic             tgt_ready_c;
   logic             capture_c;
   logic             apply_c;
   logic             err_c;

   // Decode the held target: range check, one-hot select, and whether it may be applied now
   always_comb begin
      ch_valid_c  = (32'(hold.ch) < NCH);
      tgt_ready_c = 1'b0;
      sel_c       = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (32'(hold.ch) == i) begin
            sel_c[i]    = 1'b1;
            tgt_ready_c = (div_a[i] == '0) || (cnt_a[i] == '0);
         end
      end
   end

   // Config FSM next-state: accept in IDLE, wait in PEND for a stopped target or its tick edge
   always_comb begin
      state_next = state;
      capture_c  = 1'b0;
      apply_c    = 1'b0;
      err_c      = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_valid) begin
               capture_c  = 1'b1;
               state_next = PEND;
            end
         end
         PEND: begin
            if (!ch_valid_c) begin
               err_c      = 1'b1;
               state_next = IDLE;
            end else if (tgt_ready_c) begin
               apply_c    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Config FSM state, holding register and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         hold      <= '0;
         cfg_ready <= 1'b1;
         cfg_err   <= 1'b0;
      end else begin
         state     <= state_next;
         cfg_ready <= (state_next == IDLE);
         cfg_err   <= err_c;
         if (capture_c) begin
            hold.ch  <= cfg_ch;
            hold.div <= cfg_div;
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [WIDTH-1:0] div_q;
      logic [WIDTH-1:0] cnt_q;
      logic             tick_q;
      logic             phase_q;
      logic             run_q;
      logic             apply_ch;

      assign apply_ch   = apply_c && sel_c[g];
      assign div_a[g]   = div_q;
      assign cnt_a[g]   = cnt_q;
      assign tick[g]    = tick_q;
      assign phase[g]   = phase_q;
      assign running[g] = run_q;

      // Channel counter: reload and tick on zero; a pending request lands on the same edge
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            div_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            phase_q <= 1'b0;
            run_q   <= 1'b0;
         end else begin
            if (div_q != '0) begin
               if (cnt_q == '0) begin
                  cnt_q   <= div_q - ONE;
                  tick_q  <= 1'b1;
                  phase_q <= ~phase_q;
               end else begin
                  cnt_q  <= cnt_q - ONE;
                  tick_q <= 1'b0;
               end
            end else begin
               cnt_q   <= '0;
               tick_q  <= 1'b0;
               phase_q <= 1'b0;
            end
            if (apply_ch) begin
               if (hold.div != '0) begin
                  div_q <= hold.div;
                  cnt_q <= hold.div - ONE;
                  run_q <= 1'b1;
               end else begin
                  // stop: this edge's tick still fires, but phase clears instead of toggling
                  div_q   <= '0;
                  cnt_q   <= '0;
                  phase_q <= 1'b0;
                  run_q   <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: directed scoreboard bench for tick_sched (2-channel build plus 1-channel build).
module tb_tick_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [0:0]  cfg_ch = '0;
   logic [15:0] cfg_div = '0;
   logic        cfg_ready;
   logic        cfg_err;
   logic [1:0]  tick;
   logic [1:0]  phase;
   logic [1:0]  running;

   logic        cfg_valid1 = 1'b0;
   logic [0:0]  cfg_ch1 = '0;
   logic [15:0] cfg_div1 = '0;
   logic        cfg_ready1;
   logic        cfg_err1;
   logic [0:0]  tick1;
   logic [0:0]  phase1;
   logic [0:0]  running1;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int q0 [$];
   int q1 [$];
   logic [1:0] ph_exp = 2'b00;
   int stop_at [2] = '{-1, -1};

   always #5 clk = ~clk;

   tick_sched #(.NCH(2), .CHW(1), .WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_err(cfg_err),
      .tick(tick), .phase(phase), .running(running)
   );

   tick_sched #(.NCH(1), .CHW(1), .WIDTH(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1),
      .cfg_ch(cfg_ch1), .cfg_div(cfg_div1), .cfg_err(cfg_err1),
      .tick(tick1), .phase(phase1), .running(running1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_ticks(input int ch, input int first, input int period, input int last);
      for (int c = first; c <= last; c += period) begin
         if (ch == 0) q0.push_back(c);
         else         q1.push_back(c);
      end
   endtask

   // compare one channel's tick/phase against the scoreboard for the current cycle
   task automatic mon_ch(input int ch, input logic t, input logic p);
      logic e;
      e = 1'b0;
      if (ch == 0) begin
         if (q0.size() > 0 && q0[0] == cyc) begin e = 1'b1; void'(q0.pop_front()); end
      end else begin
         if (q1.size() > 0 && q1[0] == cyc) begin e = 1'b1; void'(q1.pop_front()); end
      end
      if (e) ph_exp[ch] = (cyc == stop_at[ch]) ? 1'b0 : ~ph_exp[ch];
      chk($sformatf("tick%0d@%0d", ch, cyc), 32'(t), 32'(e));
      chk($sformatf("phase%0d@%0d", ch, cyc), 32'(p), 32'(ph_exp[ch]));
   endtask

   // advance one cycle: sample at the falling edge, then check both channels
   task automatic step();
      @(negedge clk);
      cyc++;
      mon_ch(0, tick[0], phase[0]);
      mon_ch(1, tick[1], phase[1]);
   endtask

   task automatic drive(input logic [0:0] ch, input logic [15:0] dv);
      cfg_valid = 1'b1;
      cfg_ch    = ch;
      cfg_div   = dv;
   endtask

   initial begin
      int a, t0, t, x, y, r;

      // reset state
      repeat (3) step();
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      chk("rst_err", 32'(cfg_err), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_ready1", 32'(cfg_ready1), 32'd1);
      rst_n = 1'b1;
      step();
      chk("post_rst_ready", 32'(cfg_ready), 32'd1);
      chk("post_rst_tick", 32'(tick), 32'd0);

      // out-of-range channel on the 1-channel build
      cfg_valid1 = 1'b1; cfg_ch1 = 1'b1; cfg_div1 = 16'd7;
      step();
      cfg_valid1 = 1'b0;
      chk("err_ready_low", 32'(cfg_ready1), 32'd0);
      chk("err_not_yet", 32'(cfg_err1), 32'd0);
      step();
      chk("err_pulse", 32'(cfg_err1), 32'd1);
      chk("err_ready_back", 32'(cfg_ready1), 32'd1);
      step();
      chk("err_pulse_end", 32'(cfg_err1), 32'd0);
      chk("err_running1", 32'(running1), 32'd0);
      chk("err_tick1", 32'(tick1), 32'd0);
      chk("err_phase1", 32'(phase1), 32'd0);
      chk("dut0_no_err", 32'(cfg_err), 32'd0);

      // start ch0 with div=4
      drive(1'b0, 16'd4);
      step();
      a = cyc;
      cfg_valid = 1'b0;
      chk("start_ready_low", 32'(cfg_ready), 32'd0);
      chk("start_running_pre", 32'(running[0]), 32'd0);
      t0 = a + 5;
      t  = t0 + 8;
      push_ticks(0, t0, 4, t + 4);
      step();
      chk("start_ready_high", 32'(cfg_ready), 32'd1);
      chk("start_running", 32'(running[0]), 32'd1);
      while (cyc < t) step();
      chk("phase0_third_tick", 32'(phase[0]), 32'd1);

      // retune ch0 to 10 two cycles after a tick; an ignored request rides along
      step();
      drive(1'b0, 16'd10);
      step();
      chk("retune_ready_low1", 32'(cfg_ready), 32'd0);
      push_ticks(0, t + 14, 10, t + 34);
      drive(1'b1, 16'd6);
      step();
      cfg_valid = 1'b0;
      chk("retune_ready_low2", 32'(cfg_ready), 32'd0);
      step();
      chk("retune_ready_high", 32'(cfg_ready), 32'd1);
      step();
      chk("ignored_req_ch1", 32'(running[1]), 32'd0);
      x = t + 24;
      while (cyc < x) step();

      // ch0 -> 3 at its tick, start ch1 at 5, then stop ch0
      drive(1'b0, 16'd3);
      step();
      cfg_valid = 1'b0;
      chk("div3_ready_low", 32'(cfg_ready), 32'd0);
      push_ticks(0, x + 13, 3, x + 22);
      stop_at[0] = x + 22;
      while (cyc < x + 9) step();
      chk("div3_still_pending", 32'(cfg_ready), 32'd0);
      step();
      chk("div3_applied", 32'(cfg_ready), 32'd1);
      drive(1'b1, 16'd5);
      step();
      cfg_valid = 1'b0;
      chk("ch1_ready_low", 32'(cfg_ready), 32'd0);
      push_ticks(1, x + 17, 5, x + 37);
      step();
      chk("ch1_ready_high", 32'(cfg_ready), 32'd1);
      chk("ch1_running", 32'(running[1]), 32'd1);
      while (cyc < x + 20) step();
      drive(1'b0, 16'd0);
      step();
      cfg_valid = 1'b0;
      step();
      chk("stop_running0", 32'(running[0]), 32'd0);
      chk("stop_ready", 32'(cfg_ready), 32'd1);

      // ch1 -> 1: continuous tick
      while (cyc < x + 32) step();
      drive(1'b1, 16'd1);
      step();
      cfg_valid = 1'b0;
      y = x + 40;
      push_ticks(1, x + 38, 1, y + 6);
      while (cyc < x + 37) step();
      chk("div1_ready", 32'(cfg_ready), 32'd1);
      chk("div1_running", 32'(running[1]), 32'd1);

      // reset while a request on ch0 (div=8) is pending
      while (cyc < y) step();
      drive(1'b0, 16'd8);
      step();
      cfg_valid = 1'b0;
      step();
      chk("div8_running", 32'(running[0]), 32'd1);
      drive(1'b0, 16'd2);
      step();
      cfg_valid = 1'b0;
      chk("pend_ready_low", 32'(cfg_ready), 32'd0);
      while (cyc < y + 6) step();
      chk("pend_still_low", 32'(cfg_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("arst_tick", 32'(tick), 32'd0);
      chk("arst_phase", 32'(phase), 32'd0);
      chk("arst_running", 32'(running), 32'd0);
      chk("arst_ready", 32'(cfg_ready), 32'd1);
      chk("arst_err", 32'(cfg_err), 32'd0);
      q0.delete();
      q1.delete();
      ph_exp  = 2'b00;
      stop_at = '{-1, -1};
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("rel_running", 32'(running), 32'd0);
      chk("rel_ready", 32'(cfg_ready), 32'd1);
      r = cyc;
      drive(1'b0, 16'd2);
      step();
      cfg_valid = 1'b0;
      chk("rel_accept", 32'(cfg_ready), 32'd0);
      push_ticks(0, r + 4, 2, r + 10);
      step();
      chk("rel_running0", 32'(running), 32'd1);
      while (cyc < r + 10) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
